// File: rtl/bcd_adder_serial_4digits.sv
// Digit-serial packed-BCD adder: one shared 4-bit digit adder with +6 correction, LSD first.
// Latency DIGITS cycles from accepted start to done; start is ignored while busy (no other backpressure).
module bcd_adder_serial_4digits #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            invalid_q, invalid_d;

    logic [4:0]      dig_sum;
    logic [4:0]      dig_adj;
    logic [3:0]      dig;
    logic            c_nxt;

    // Operands are shifted right each digit so the adder always reads nibble 0;
    // sum is shifted in from the top so digit i lands in [4i+3:4i] after the last step.
    always_comb begin
        dig_sum = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
        dig_adj = dig_sum + 5'd6;
        dig     = dig_sum[3:0];
        c_nxt   = 1'b0;
        if (dig_sum > 5'd9) begin
            dig   = dig_adj[3:0];
            c_nxt = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        invalid_d = invalid_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    carry_d   = cin;
                    cnt_d     = '0;
                    invalid_d = 1'b0;
                    state_d   = RUN;
                end else begin
                    state_d   = IDLE;
                end
            end
            RUN: begin
                a_d            = a_q >> 4;
                b_d            = b_q >> 4;
                carry_d        = c_nxt;
                sum_d          = sum_q >> 4;
                sum_d[W-1 -: 4] = dig;
                invalid_d      = invalid_q | (a_q[3:0] > 4'd9) | (b_q[3:0] > 4'd9);
                cnt_d          = cnt_q + CW'(1);
                if (cnt_q == CW'(DIGITS - 1)) begin
                    cout_d  = c_nxt;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            invalid_q <= invalid_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_adder_serial_4digits.sv
// Randomized self-checking bench for the digit-serial BCD adder against a decimal reference model.
module tb_bcd_adder_serial_4digits;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin_in = 1'b0;
    logic         busy, done, cout, invalid;
    logic [W-1:0] sum;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bcd_adder_serial_4digits #(.DIGITS(D)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a_in),
        .b      (b_in),
        .cin    (cin_in),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .invalid(invalid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Valid operands: plain decimal addition. Invalid digits: the per-digit rule.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c_in,
                         output logic [W-1:0] s, output logic co, output logic inv);
        int ad, bd, dec_a, dec_b, total, c, t, scale;
        inv = 1'b0;
        for (int i = 0; i < D; i++) begin
            ad = int'(a[4*i +: 4]);
            bd = int'(b[4*i +: 4]);
            if (ad > 9 || bd > 9) inv = 1'b1;
        end
        s = '0;
        if (!inv) begin
            dec_a = 0; dec_b = 0; scale = 1;
            for (int i = 0; i < D; i++) begin
                dec_a += int'(a[4*i +: 4]) * scale;
                dec_b += int'(b[4*i +: 4]) * scale;
                scale *= 10;
            end
            total = dec_a + dec_b + int'(c_in);
            co = (total >= scale);
            total = total % scale;
            for (int i = 0; i < D; i++) begin
                s[4*i +: 4] = 4'(total % 10);
                total /= 10;
            end
        end else begin
            c = int'(c_in);
            for (int i = 0; i < D; i++) begin
                t = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
                if (t > 9) begin
                    s[4*i +: 4] = 4'((t + 6) % 16);
                    c = 1;
                end else begin
                    s[4*i +: 4] = 4'(t);
                    c = 0;
                end
            end
            co = c[0];
        end
    endtask

    // Waits (bounded) for done, counting cycles and busy cycles since the first negedge after E0.
    task automatic wait_done(input string tag, output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c);
        logic [W-1:0] es;
        logic eco, einv;
        int cyc, bc;
        model(a, b, c, es, eco, einv);
        @(negedge clk);
        a_in = a; b_in = b; cin_in = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom); cin_in = 1'($urandom);
        wait_done(tag, cyc, bc);
        check({tag, "_lat"}, 32'(cyc), 32'(D));
        check({tag, "_busycyc"}, 32'(bc), 32'(D));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(eco));
        check({tag, "_inv"}, 32'(invalid), 32'(einv));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_sum_hold"}, 32'(sum), 32'(es));
    endtask

    initial begin
        logic [W-1:0] ra, rb, es;
        logic eco, einv;
        int cyc, bc, gap, dcnt;

        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_inv", 32'(invalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("basic", 16'h1234, 16'h5678, 1'b0);
        run_op("ripple", 16'h9999, 16'h0001, 1'b0);
        run_op("max", 16'h9999, 16'h9999, 1'b1);
        run_op("zero_cin", 16'h0000, 16'h0000, 1'b1);
        run_op("invalid", 16'h00A0, 16'h0000, 1'b0);
        run_op("inv_clear", 16'h0001, 16'h0001, 1'b0);

        // start held high; operands changed after acceptance
        @(negedge clk);
        a_in = 16'h4321; b_in = 16'h1289; cin_in = 1'b0; start = 1'b1;
        model(16'h4321, 16'h1289, 1'b0, es, eco, einv);
        @(negedge clk);
        a_in = 16'h1111; b_in = 16'h1111;
        wait_done("b2b1", cyc, bc);
        check("b2b1_lat", 32'(cyc), 32'(D));
        check("b2b1_sum", 32'(sum), 32'(es));
        check("b2b1_cout", 32'(cout), 32'(eco));
        @(negedge clk);
        check("b2b_done_drop", 32'(done), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        gap = 1;
        while (!done && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        start = 1'b0;
        check("b2b_gap", 32'(gap), 32'(D + 1));
        check("b2b2_sum", 32'(sum), 32'h2222);
        check("b2b2_cout", 32'(cout), 32'd0);
        @(negedge clk);
        check("b2b_idle", 32'(busy | done), 32'd0);

        // reset mid-RUN
        @(negedge clk);
        a_in = 16'h5555; b_in = 16'h5555; cin_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        check("mid_rst_inv", 32'(invalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("post_rst_quiet", 32'(dcnt), 32'd0);
        run_op("post_rst", 16'h0005, 16'h0005, 1'b0);

        // randomized operations, occasional invalid digits
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < D; i++) begin
                ra[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
                rb[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
            end
            run_op($sformatf("rnd%0d", n), ra, rb, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
